sdcard_blk_arb: RTL and testbench
=================================

// Module: sdcard_blk_arb
// PURPOSE
//  Shares one sdcard phy between NREQ block-level requesters (e.g. bootloader DMA, CPU block dev).
//  Round-robin grants a 512-byte read (CMD17) or write (CMD24), drives the phy cmd queue, and
//  routes the phy rx/tx byte streams to/from the granted requester until the block completes.
//  Sits between requester ports and the phy's pop/push interface.
// PARAMETERS
//  NREQ       2   number of requesters (1..8)
//  ADDRBITSZ  32  block-address width
//  BLKSZ      512 bytes per block (power of 2)
// PORTS
//  clk_i           in  1             clock
//  rst_ni          in  1             async active-low reset
//  req_valid_i     in  NREQ          requester i has a command pending
//  req_wr_i        in  NREQ          1=write block, 0=read block
//  req_addr_i      in  NREQ*ADDRBITSZ block address per requester (slice i)
//  req_ack_o       out NREQ          1-cycle pulse: command accepted (granted)
//  rx_valid_o      out NREQ          read byte available to requester i
//  rx_data_o       out 8             read byte (shared; qualified by rx_valid_o)
//  rx_ready_i      in  NREQ          requester i consumes rx byte
//  tx_valid_i      in  NREQ          requester i has write byte
//  tx_data_i       in  NREQ*8        write byte per requester
//  tx_ready_o      out NREQ          write byte i consumed this cycle
//  done_o          out NREQ          1-cycle pulse: block finished for requester i
//  err_o           out NREQ          1-cycle pulse with done_o: block failed
//  phy_cmd_pop_i   in  1             phy pops command
//  phy_cmd_data_o  out 1             1=CMD24, 0=CMD17
//  phy_cmdaddr_o   out ADDRBITSZ     block address to phy
//  phy_cmd_empty_o out 1             no command offered
//  phy_rx_push_i   in  1             phy pushes read byte
//  phy_rx_data_i   in  8             read byte
//  phy_rx_full_o   out 1             granted requester not ready
//  phy_tx_pop_i    in  1             phy pops write byte
//  phy_tx_data_o   out 8             write byte
//  phy_tx_empty_o  out 1             granted requester has no byte
//  phy_blkcnt_i    in  ADDRBITSZ     card capacity in blocks
//  phy_err_i       in  1             phy error level
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=IDLE, grant=0, priority ptr=0, cntr=0; all outputs 0 except
//   phy_cmd_empty_o=1, phy_rx_full_o=1, phy_tx_empty_o=1.
//  FSM IDLE->ISSUE->XFER->DONE->IDLE; IDLE->FAIL->IDLE.
//  IDLE: if any req_valid_i, round-robin pick from ptr; latch grant,wr,addr; pulse req_ack_o[g].
//   If addr>=phy_blkcnt_i or phy_err_i: ->FAIL, else ->ISSUE. Grant at most one per cycle.
//  ISSUE: phy_cmd_empty_o=0 with latched data/addr; on phy_cmd_pop_i ->XFER, cntr=0.
//  XFER read: phy_rx_full_o=~rx_ready_i[g]; rx_valid_o[g]=phy_rx_push_i; byte counted on
//   phy_rx_push_i & ~phy_rx_full_o. Push while full is a phy fault: byte dropped, not counted.
//  XFER write: phy_tx_empty_o=~tx_valid_i[g]; phy_tx_data_o=tx_data_i[g];
//   tx_ready_o[g]=phy_tx_pop_i & tx_valid_i[g]; counted on same condition.
//  Count reaching BLKSZ-1 and transferring ->DONE. cntr is clog2(BLKSZ) bits, never wraps.
//  phy_err_i in ISSUE/XFER: abort ->DONE with err flag set; command not retried.
//  DONE/FAIL: pulse done_o[g] (err_o[g] if FAIL or aborted); ptr=g+1 mod NREQ; ->IDLE.
//  Min latency req_valid_i -> first phy_cmd_pop_i possible: 2 cycles. Requester must hold
//   req_* stable until req_ack_o; may reassert next request any time after done_o.
//  Non-granted requesters: rx_valid_o/tx_ready_o/done_o/err_o stay 0.
//  Reset mid-block: immediate abort, no done_o; phy must be reset together.
// STRUCTURE
//  Shared header lib/sdcard_defs.vh: ADDRBITSZ, BLKSZ, state encodings, CMD17/CMD24 flag values.
//  One sub-module: rr_arbiter (NREQ req, ptr -> one-hot grant + index), combinational.
//  Byte counter, FSM and muxing in top; no FIFOs (phy side buffers).
// TESTING
//  Single read: req0 rd addr=3 -> 1 cmd pop (data=0,addr=3), 512 bytes to req0, done_o[0] only.
//  Single write: req1 wr addr=7, tx bytes 0..255 x2 -> 512 tx pops, phy stores them, done_o[1].
//  Contention: req0,req1 valid same cycle, ptr=0 -> req0 first, req1 next; then ptr=0 again.
//  Backpressure: rx_ready_i[0] toggling 50% -> exactly 512 bytes counted, none lost, done once.
//  Bounds: addr=phy_blkcnt_i -> no cmd pop, done_o+err_o pulse 1 cycle after ack.
//  Abort/reset: phy_err_i at byte 100 -> done+err; rst_ni low at byte 200 -> outputs to reset values.

Source files
------------

// File: rtl/sdcard_blk_arb_pkg.sv
// Shared definitions for the sdcard block arbiter: defaults, command flags, FSM states.
package sdcard_blk_arb_pkg;

  localparam int DEF_ADDRBITSZ = 32;
  localparam int DEF_BLKSZ     = 512;

  // Command flag presented to the phy on phy_cmd_data_o
  localparam logic CMD17 = 1'b0;  // single block read
  localparam logic CMD24 = 1'b1;  // single block write

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_XFER  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  // Index width for n requesters; a single requester still gets one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdcard_blk_arb_if.sv
// Requester and phy signal bundle for the sdcard block arbiter.
// slave = arbiter side, master = requesters + phy side.
interface sdcard_blk_arb_if #(
  parameter int NREQ      = 2,
  parameter int ADDRBITSZ = sdcard_blk_arb_pkg::DEF_ADDRBITSZ
);
  // requester side
  logic [NREQ-1:0]                req_valid_i;
  logic [NREQ-1:0]                req_wr_i;
  logic [NREQ-1:0][ADDRBITSZ-1:0] req_addr_i;
  logic [NREQ-1:0]                req_ack_o;
  logic [NREQ-1:0]                rx_valid_o;
  logic [7:0]                     rx_data_o;
  logic [NREQ-1:0]                rx_ready_i;
  logic [NREQ-1:0]                tx_valid_i;
  logic [NREQ-1:0][7:0]           tx_data_i;
  logic [NREQ-1:0]                tx_ready_o;
  logic [NREQ-1:0]                done_o;
  logic [NREQ-1:0]                err_o;
  // phy side
  logic                           phy_cmd_pop_i;
  logic                           phy_cmd_data_o;
  logic [ADDRBITSZ-1:0]           phy_cmdaddr_o;
  logic                           phy_cmd_empty_o;
  logic                           phy_rx_push_i;
  logic [7:0]                     phy_rx_data_i;
  logic                           phy_rx_full_o;
  logic                           phy_tx_pop_i;
  logic [7:0]                     phy_tx_data_o;
  logic                           phy_tx_empty_o;
  logic [ADDRBITSZ-1:0]           phy_blkcnt_i;
  logic                           phy_err_i;

  modport slave (
    input  req_valid_i, req_wr_i, req_addr_i, rx_ready_i, tx_valid_i, tx_data_i,
           phy_cmd_pop_i, phy_rx_push_i, phy_rx_data_i, phy_tx_pop_i, phy_blkcnt_i, phy_err_i,
    output req_ack_o, rx_valid_o, rx_data_o, tx_ready_o, done_o, err_o,
           phy_cmd_data_o, phy_cmdaddr_o, phy_cmd_empty_o, phy_rx_full_o,
           phy_tx_data_o, phy_tx_empty_o
  );

  modport master (
    output req_valid_i, req_wr_i, req_addr_i, rx_ready_i, tx_valid_i, tx_data_i,
           phy_cmd_pop_i, phy_rx_push_i, phy_rx_data_i, phy_tx_pop_i, phy_blkcnt_i, phy_err_i,
    input  req_ack_o, rx_valid_o, rx_data_o, tx_ready_o, done_o, err_o,
           phy_cmd_data_o, phy_cmdaddr_o, phy_cmd_empty_o, phy_rx_full_o,
           phy_tx_data_o, phy_tx_empty_o
  );

endinterface

// File: rtl/sdcard_blk_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module sdcard_blk_arb_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan NREQ slots starting at ptr; the first hit wins
  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int off = 0; off < NREQ; off++) begin
      k = (int'(ptr) + off) % NREQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/sdcard_blk_arb.sv
// Shares one sdcard phy between NREQ block requesters. One 512-byte CMD17/CMD24 at a time,
// round-robin granted; rx/tx byte streams are steered to the granted requester until the
// block completes, aborts on phy error, or fails the capacity check.
module sdcard_blk_arb
  import sdcard_blk_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDRBITSZ = DEF_ADDRBITSZ,
  parameter int BLKSZ     = DEF_BLKSZ
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  sdcard_blk_arb_if.slave  bus
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(BLKSZ);
  localparam logic [CW-1:0] LAST = CW'(BLKSZ - 1);

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gidx;
  logic [NREQ-1:0]      gsel;
  logic                 wr;
  logic [ADDRBITSZ-1:0] addr;
  logic [CW-1:0]        cntr;
  logic                 abort_err;
  logic [NREQ-1:0]      ack_r, done_r, err_r;

  logic [NREQ-1:0]      arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 rx_xfer, tx_xfer;

  sdcard_blk_arb_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (bus.req_valid_i),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign bus.req_ack_o       = ack_r;
  assign bus.done_o          = done_r;
  assign bus.err_o           = err_r;
  assign bus.phy_cmd_empty_o = (state != ST_ISSUE);
  assign bus.phy_cmd_data_o  = wr ? CMD24 : CMD17;
  assign bus.phy_cmdaddr_o   = addr;

  // Byte-stream steering: only the granted requester sees the phy, and only during XFER.
  // A phy push while full still shows rx_valid but is neither consumed nor counted.
  always_comb begin
    bus.rx_valid_o     = '0;
    bus.rx_data_o      = '0;
    bus.tx_ready_o     = '0;
    bus.phy_rx_full_o  = 1'b1;
    bus.phy_tx_empty_o = 1'b1;
    bus.phy_tx_data_o  = '0;
    rx_xfer            = 1'b0;
    tx_xfer            = 1'b0;
    if (state == ST_XFER && !wr) begin
      bus.phy_rx_full_o = ~bus.rx_ready_i[gidx];
      bus.rx_data_o     = bus.phy_rx_data_i;
      if (bus.phy_rx_push_i) bus.rx_valid_o = gsel;
      rx_xfer = bus.phy_rx_push_i & bus.rx_ready_i[gidx];
    end
    if (state == ST_XFER && wr) begin
      bus.phy_tx_empty_o = ~bus.tx_valid_i[gidx];
      bus.phy_tx_data_o  = bus.tx_data_i[gidx];
      tx_xfer = bus.phy_tx_pop_i & bus.tx_valid_i[gidx];
      if (tx_xfer) bus.tx_ready_o = gsel;
    end
  end

  // Block FSM: grant, issue command, count bytes, report completion, advance priority
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      gsel      <= '0;
      wr        <= 1'b0;
      addr      <= '0;
      cntr      <= '0;
      abort_err <= 1'b0;
      ack_r     <= '0;
      done_r    <= '0;
      err_r     <= '0;
    end else begin
      ack_r  <= '0;
      done_r <= '0;
      err_r  <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            gidx      <= arb_idx;
            gsel      <= arb_gnt;
            wr        <= bus.req_wr_i[arb_idx];
            addr      <= bus.req_addr_i[arb_idx];
            ack_r     <= arb_gnt;
            abort_err <= 1'b0;
            // Out-of-range address or a phy already in error never reaches the phy
            if (bus.req_addr_i[arb_idx] >= bus.phy_blkcnt_i || bus.phy_err_i) state <= ST_FAIL;
            else                                                              state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.phy_err_i) begin
            abort_err <= 1'b1;
            state     <= ST_DONE;
          end else if (bus.phy_cmd_pop_i) begin
            cntr  <= '0;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (bus.phy_err_i) begin
            abort_err <= 1'b1;
            state     <= ST_DONE;
          end else if (rx_xfer || tx_xfer) begin
            if (cntr == LAST) state <= ST_DONE;
            else              cntr  <= cntr + CW'(1);
          end
        end
        ST_DONE, ST_FAIL: begin
          done_r <= gsel;
          err_r  <= (state == ST_FAIL || abort_err) ? gsel : '0;
          ptr    <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdcard_blk_arb.sv
// Directed bench for sdcard_blk_arb: acks, commands, rx/tx bytes and completions are
// predicted into queues as stimulus is driven and checked as the DUT produces them.
module tb_sdcard_blk_arb;

  localparam int NREQ   = 2;
  localparam int AW     = 32;
  localparam int BLKCNT = 1000;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  sdcard_blk_arb_if #(.NREQ(NREQ), .ADDRBITSZ(AW)) bus();

  sdcard_blk_arb #(.NREQ(NREQ), .ADDRBITSZ(AW), .BLKSZ(512)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int idx;
    bit err;
    bit lat1;  // completion must follow the ack by exactly one cycle
  } evt_t;

  int          ack_q[$];
  logic [32:0] cmd_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  evt_t        evt_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int cur_r = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // ack monitor
  always @(negedge clk_i) begin
    if (rst_ni && bus.req_ack_o != '0) begin
      if (ack_q.size() == 0) check("ack_unexpected", 64'(bus.req_ack_o), 64'd0);
      else check("ack", 64'(bus.req_ack_o), 64'd1 << ack_q.pop_front());
      ack_cyc <= cyc;
    end
  end

  // completion monitor
  always @(negedge clk_i) begin
    if (rst_ni && bus.done_o != '0) begin
      if (evt_q.size() == 0) check("done_unexpected", 64'(bus.done_o), 64'd0);
      else begin
        evt_t e;
        e = evt_q.pop_front();
        check("done", 64'(bus.done_o), 64'd1 << e.idx);
        check("err", 64'(bus.err_o), e.err ? (64'd1 << e.idx) : 64'd0);
        if (e.lat1) check("fail_latency", 64'(cyc - ack_cyc), 64'd1);
      end
    end else if (rst_ni && bus.err_o != '0) begin
      check("err_without_done", 64'(bus.err_o), 64'd0);
    end
  end

  // phy command monitor
  always @(negedge clk_i) begin
    if (rst_ni && bus.phy_cmd_pop_i && !bus.phy_cmd_empty_o) begin
      if (cmd_q.size() == 0) check("cmd_unexpected", 64'(bus.phy_cmdaddr_o), 64'hFFFF_FFFF_FFFF);
      else check("cmd", 64'({bus.phy_cmd_data_o, bus.phy_cmdaddr_o}), 64'(cmd_q.pop_front()));
    end
  end

  // rx byte monitor
  always @(negedge clk_i) begin
    if (rst_ni && bus.rx_valid_o != '0) begin
      check("rx_sel", 64'(bus.rx_valid_o), 64'd1 << cur_r);
      if ((bus.rx_valid_o & bus.rx_ready_i) != '0) begin
        if (rx_q.size() == 0) check("rx_unexpected", 64'(bus.rx_data_o), 64'h1FF);
        else check("rx_data", 64'(bus.rx_data_o), 64'(rx_q.pop_front()));
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  // tx byte monitor
  always @(negedge clk_i) begin
    if (rst_ni && bus.tx_ready_o != '0) begin
      check("tx_sel", 64'(bus.tx_ready_o), 64'd1 << cur_r);
      if (tx_q.size() == 0) check("tx_unexpected", 64'(bus.phy_tx_data_o), 64'h1FF);
      else check("tx_data", 64'(bus.phy_tx_data_o), 64'(tx_q.pop_front()));
      tx_cnt <= tx_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_ack"},      64'(bus.req_ack_o),       64'd0);
    check({tag, "_done"},     64'(bus.done_o),          64'd0);
    check({tag, "_err"},      64'(bus.err_o),           64'd0);
    check({tag, "_rxv"},      64'(bus.rx_valid_o),      64'd0);
    check({tag, "_txr"},      64'(bus.tx_ready_o),      64'd0);
    check({tag, "_cmdempty"}, 64'(bus.phy_cmd_empty_o), 64'd1);
    check({tag, "_rxfull"},   64'(bus.phy_rx_full_o),   64'd1);
    check({tag, "_txempty"},  64'(bus.phy_tx_empty_o),  64'd1);
    check({tag, "_cmd"},      64'({bus.phy_cmd_data_o, bus.phy_cmdaddr_o}), 64'd0);
    check({tag, "_data"},     64'({bus.rx_data_o, bus.phy_tx_data_o}), 64'd0);
  endtask

  task automatic request(input int r, input bit wr, input logic [AW-1:0] addr);
    bus.req_wr_i[r]    = wr;
    bus.req_addr_i[r]  = addr;
    bus.req_valid_i[r] = 1'b1;
  endtask

  task automatic wait_ack(input int r);
    int n = 0;
    while (!bus.req_ack_o[r] && n < 20) begin
      tick;
      n++;
    end
    check("ack_wait", 64'(n < 20), 64'd1);
    bus.req_valid_i[r] = 1'b0;
  endtask

  task automatic phy_cmd;
    int n = 0;
    while (bus.phy_cmd_empty_o && n < 20) begin
      tick;
      n++;
    end
    check("cmd_wait", 64'(n < 20), 64'd1);
    bus.phy_cmd_pop_i = 1'b1;
    tick;
    bus.phy_cmd_pop_i = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (evt_q.size() != 0 && n < 50) begin
      tick;
      n++;
    end
    check("done_wait", 64'(evt_q.size()), 64'd0);
  endtask

  // Phy pushes nstop bytes to requester r; bp toggles rx_ready, faulty adds pushes while full
  task automatic rd_block(input int r, input int nstop, input bit bp, input bit faulty);
    int i = 0;
    int guard = 0;
    while (i < nstop && guard < 5000) begin
      bus.rx_ready_i[r] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.phy_rx_data_i = 8'($urandom);
      if (bus.rx_ready_i[r]) begin
        bus.phy_rx_push_i = 1'b1;
        rx_q.push_back(bus.phy_rx_data_i);
        i++;
      end else begin
        bus.phy_rx_push_i = faulty && ($urandom_range(0, 3) == 0);
      end
      tick;
      guard++;
    end
    bus.phy_rx_push_i = 1'b0;
    bus.rx_ready_i[r] = 1'b1;
    check("rd_guard", 64'(guard < 5000), 64'd1);
  endtask

  // Requester r supplies bytes 0..255 twice with gaps; phy pops irregularly
  task automatic wr_block(input int r);
    int i = 0;
    int guard = 0;
    while (i < 512 && guard < 5000) begin
      bus.tx_valid_i[r] = ($urandom_range(0, 3) != 0);
      bus.tx_data_i[r]  = 8'(i);
      bus.phy_tx_pop_i  = ($urandom_range(0, 4) != 0);
      if (bus.tx_valid_i[r] && bus.phy_tx_pop_i) begin
        tx_q.push_back(8'(i));
        i++;
      end
      tick;
      guard++;
    end
    bus.tx_valid_i[r] = 1'b0;
    bus.phy_tx_pop_i  = 1'b0;
    check("wr_guard", 64'(guard < 5000), 64'd1);
  endtask

  // Both requesters out of range at once: order shows where the priority pointer sits
  task automatic oob_pair;
    ack_q.push_back(0);
    ack_q.push_back(1);
    evt_q.push_back('{0, 1'b1, 1'b1});
    evt_q.push_back('{1, 1'b1, 1'b1});
    request(0, 1'b0, AW'(BLKCNT));
    request(1, 1'b1, AW'(BLKCNT + 5));
    wait_ack(0);
    wait_ack(1);
    wait_idle;
  endtask

  initial begin
    bus.req_valid_i   = '0;
    bus.req_wr_i      = '0;
    bus.req_addr_i    = '0;
    bus.rx_ready_i    = '1;
    bus.tx_valid_i    = '0;
    bus.tx_data_i     = '0;
    bus.phy_cmd_pop_i = 1'b0;
    bus.phy_rx_push_i = 1'b0;
    bus.phy_rx_data_i = '0;
    bus.phy_tx_pop_i  = 1'b0;
    bus.phy_blkcnt_i  = AW'(BLKCNT);
    bus.phy_err_i     = 1'b0;

    // reset state
    repeat (3) tick;
    check_rst("reset");
    rst_ni = 1'b1;
    tick;

    // single read, req0 addr 3
    cur_r = 0;
    ack_q.push_back(0);
    cmd_q.push_back({1'b0, 32'd3});
    request(0, 1'b0, 32'd3);
    wait_ack(0);
    phy_cmd;
    rd_block(0, 512, 1'b0, 1'b0);
    evt_q.push_back('{0, 1'b0, 1'b0});
    wait_idle;
    check("rd_count", 64'(rx_cnt), 64'd512);

    // single write, req1 addr 7; req0 waves junk that must stay unselected
    cur_r = 1;
    bus.tx_valid_i[0] = 1'b1;
    bus.tx_data_i[0]  = 8'hEE;
    ack_q.push_back(1);
    cmd_q.push_back({1'b1, 32'd7});
    request(1, 1'b1, 32'd7);
    wait_ack(1);
    phy_cmd;
    wr_block(1);
    bus.tx_valid_i[0] = 1'b0;
    evt_q.push_back('{1, 1'b0, 1'b0});
    wait_idle;
    check("wr_count", 64'(tx_cnt), 64'd512);

    // contention with ptr back at 0: req0 served first, req1 right after
    cur_r = 0;
    ack_q.push_back(0);
    ack_q.push_back(1);
    cmd_q.push_back({1'b0, 32'd10});
    cmd_q.push_back({1'b0, 32'(BLKCNT - 1)});
    request(0, 1'b0, 32'd10);
    request(1, 1'b0, 32'(BLKCNT - 1));
    wait_ack(0);
    phy_cmd;
    rd_block(0, 512, 1'b0, 1'b0);
    evt_q.push_back('{0, 1'b0, 1'b0});
    wait_idle;
    cur_r = 1;
    wait_ack(1);
    phy_cmd;
    rd_block(1, 512, 1'b0, 1'b0);
    evt_q.push_back('{1, 1'b0, 1'b0});
    wait_idle;

    // bounds: addr == capacity fails one cycle after ack; ptr must be 0 again
    oob_pair;

    // backpressure on req0 with stray pushes while full
    cur_r = 0;
    rx_cnt = 0;
    ack_q.push_back(0);
    cmd_q.push_back({1'b0, 32'd42});
    request(0, 1'b0, 32'd42);
    wait_ack(0);
    phy_cmd;
    rd_block(0, 512, 1'b1, 1'b1);
    evt_q.push_back('{0, 1'b0, 1'b0});
    wait_idle;
    check("bp_count", 64'(rx_cnt), 64'd512);

    // phy already in error at grant: no command, immediate fail
    bus.phy_err_i = 1'b1;
    ack_q.push_back(1);
    evt_q.push_back('{1, 1'b1, 1'b1});
    request(1, 1'b0, 32'd5);
    wait_ack(1);
    bus.phy_err_i = 1'b0;
    wait_idle;

    // phy error at byte 100 aborts with err
    cur_r = 0;
    ack_q.push_back(0);
    cmd_q.push_back({1'b0, 32'd20});
    request(0, 1'b0, 32'd20);
    wait_ack(0);
    phy_cmd;
    rd_block(0, 100, 1'b0, 1'b0);
    bus.phy_err_i = 1'b1;
    evt_q.push_back('{0, 1'b1, 1'b0});
    tick;
    bus.phy_err_i = 1'b0;
    wait_idle;

    // reset at byte 200: outputs drop immediately, no completion
    cur_r = 1;
    ack_q.push_back(1);
    cmd_q.push_back({1'b0, 32'd30});
    request(1, 1'b0, 32'd30);
    wait_ack(1);
    phy_cmd;
    bus.phy_rx_push_i = 1'b1;
    rd_block(1, 200, 1'b0, 1'b0);
    bus.phy_rx_push_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    check_rst("midrst");
    bus.phy_rx_push_i = 1'b0;
    tick;
    tick;
    rst_ni = 1'b1;
    repeat (3) tick;
    check("midrst_no_done", 64'(evt_q.size() + rx_q.size()), 64'd0);

    // priority pointer restarts at 0 after reset
    oob_pair;

    repeat (2) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
